// File: rtl/ee457_mem_pkg.sv
// Shared types and defaults for the EE457 unified-memory arbiter.
package ee457_mem_pkg;

    localparam int ADDR_W_DEF     = 32;
    localparam int DATA_W_DEF     = 32;
    localparam int STARVE_MAX_DEF = 4;

    // State encodings are fixed so a debugger or checker can decode state_o directly.
    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_I_BUSY = 2'd1;
    localparam logic [1:0] ST_D_BUSY = 2'd2;
    localparam logic [1:0] ST_DONE   = 2'd3;

    typedef enum logic [1:0] {
        IDLE   = ST_IDLE,
        I_BUSY = ST_I_BUSY,
        D_BUSY = ST_D_BUSY,
        DONE   = ST_DONE
    } state_e;

    typedef enum logic [1:0] {
        GNT_NONE = 2'd0,
        GNT_I    = 2'd1,
        GNT_D    = 2'd2
    } gnt_e;

endpackage

// File: rtl/ee457_arb_prio.sv
// Grant decision: data wins unless fetch has already lost STARVE_MAX times in a row.
module ee457_arb_prio
    import ee457_mem_pkg::*;
#(
    parameter int STARVE_MAX = STARVE_MAX_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic i_req,
    input  logic d_req,
    input  logic grant_en,
    output gnt_e gnt_o
);

    localparam int CW = $clog2(STARVE_MAX + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(STARVE_MAX);

    logic [CW-1:0] starve_cnt_q;
    logic [CW-1:0] starve_cnt_d;

    // Pick the winner; only meaningful while the FSM is idle.
    always_comb begin
        gnt_o = GNT_NONE;
        if (grant_en) begin
            if (d_req && (!i_req || (starve_cnt_q < CNT_MAX))) begin
                gnt_o = GNT_D;
            end else if (i_req) begin
                gnt_o = GNT_I;
            end
        end
    end

    // Count D grants that bypassed a waiting fetch; any other grant clears it.
    always_comb begin
        starve_cnt_d = starve_cnt_q;
        case (gnt_o)
            GNT_I: starve_cnt_d = '0;
            GNT_D: begin
                if (i_req) begin
                    starve_cnt_d = (starve_cnt_q == CNT_MAX) ? CNT_MAX : starve_cnt_q + 1'b1;
                end else begin
                    starve_cnt_d = '0;
                end
            end
            default: starve_cnt_d = starve_cnt_q;
        endcase
    end

    // Starvation counter register.
    always_ff @(posedge clk) begin
        if (rst) begin
            starve_cnt_q <= '0;
        end else begin
            starve_cnt_q <= starve_cnt_d;
        end
    end

endmodule

// File: rtl/ee457_mem_arbiter.sv
// Serialises CPU fetch and data accesses onto one handshaked unified memory.
//
// Handshake: CPU requests (i_req, d_read/d_write) are levels held until the
// matching ready pulse, which lasts exactly one cycle; the CPU must drop or
// renew the request by the next edge. Toward memory, mem_req and its fields
// are held until mem_ack is seen high in a BUSY state; mem_ack anywhere else
// has no effect.
module ee457_mem_arbiter
    import ee457_mem_pkg::*;
#(
    parameter int ADDR_W     = ADDR_W_DEF,
    parameter int DATA_W     = DATA_W_DEF,
    parameter int STARVE_MAX = STARVE_MAX_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic [DATA_W-1:0] i_rdata,
    output logic              i_ready,
    input  logic              d_read,
    input  logic              d_write,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_ready,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack,
    output logic              stall_if,
    output logic              stall_mem,
    output logic [1:0]        state_o
);

    state_e            state_q;
    logic              mem_req_q;
    logic              mem_we_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [DATA_W-1:0] mem_wdata_q;
    logic [DATA_W-1:0] i_rdata_q;
    logic [DATA_W-1:0] d_rdata_q;
    logic              i_ready_q;
    logic              d_ready_q;

    logic d_req;
    logic grant_en;
    gnt_e gnt;

    assign d_req    = d_read | d_write;
    assign grant_en = (state_q == IDLE);

    ee457_arb_prio #(
        .STARVE_MAX(STARVE_MAX)
    ) u_prio (
        .clk     (clk),
        .rst     (rst),
        .i_req   (i_req),
        .d_req   (d_req),
        .grant_en(grant_en),
        .gnt_o   (gnt)
    );

    // Access FSM: grant in IDLE, wait for ack in BUSY, one-cycle ready in DONE.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            i_rdata_q   <= '0;
            d_rdata_q   <= '0;
            i_ready_q   <= 1'b0;
            d_ready_q   <= 1'b0;
        end else begin
            i_ready_q <= 1'b0;
            d_ready_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    case (gnt)
                        GNT_D: begin
                            // Both read and write high resolves to a write.
                            mem_addr_q  <= d_addr;
                            mem_we_q    <= d_write;
                            mem_wdata_q <= d_wdata;
                            mem_req_q   <= 1'b1;
                            state_q     <= D_BUSY;
                        end
                        GNT_I: begin
                            mem_addr_q <= i_addr;
                            mem_we_q   <= 1'b0;
                            mem_req_q  <= 1'b1;
                            state_q    <= I_BUSY;
                        end
                        default: begin
                        end
                    endcase
                end
                I_BUSY: begin
                    if (mem_ack) begin
                        mem_req_q <= 1'b0;
                        i_rdata_q <= mem_rdata;
                        i_ready_q <= 1'b1;
                        state_q   <= DONE;
                    end
                end
                D_BUSY: begin
                    if (mem_ack) begin
                        mem_req_q <= 1'b0;
                        if (!mem_we_q) begin
                            d_rdata_q <= mem_rdata;
                        end
                        d_ready_q <= 1'b1;
                        state_q   <= DONE;
                    end
                end
                DONE: begin
                    // Requests still high here are the ones just served; never regrant.
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign i_rdata   = i_rdata_q;
    assign d_rdata   = d_rdata_q;
    assign i_ready   = i_ready_q;
    assign d_ready   = d_ready_q;
    assign stall_if  = i_req & ~i_ready_q;
    assign stall_mem = d_req & ~d_ready_q;
    assign state_o   = state_q;

endmodule

// File: tb/tb_ee457_mem_arbiter.sv
// Directed bench for ee457_mem_arbiter with a small handshaked memory model.
module tb_ee457_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_req;
    logic [31:0] i_addr;
    logic [31:0] i_rdata;
    logic        i_ready;
    logic        d_read;
    logic        d_write;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [31:0] d_rdata;
    logic        d_ready;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ack;
    logic        stall_if;
    logic        stall_mem;
    logic [1:0]  state_o;

    int total = 0;
    int bad   = 0;

    logic [31:0] mem_arr [0:255];
    bit          model_en;
    int          ack_delay;
    int          busy_cnt;

    logic [31:0] exp_q[$];
    logic [31:0] gnt_log[$];

    // clock / reset
    always #5 clk = ~clk;

    ee457_mem_arbiter #(
        .ADDR_W    (32),
        .DATA_W    (32),
        .STARVE_MAX(4)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .i_req    (i_req),
        .i_addr   (i_addr),
        .i_rdata  (i_rdata),
        .i_ready  (i_ready),
        .d_read   (d_read),
        .d_write  (d_write),
        .d_addr   (d_addr),
        .d_wdata  (d_wdata),
        .d_rdata  (d_rdata),
        .d_ready  (d_ready),
        .mem_req  (mem_req),
        .mem_we   (mem_we),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata),
        .mem_ack  (mem_ack),
        .stall_if (stall_if),
        .stall_mem(stall_mem),
        .state_o  (state_o)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst     = 1'b1;
        i_req   = 1'b0;
        d_read  = 1'b0;
        d_write = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        gnt_log.delete();
        exp_q.delete();
    endtask

    task automatic check_grants(input string tag);
        check({tag, "_n"}, 32'(gnt_log.size()), 32'(exp_q.size()));
        while (exp_q.size() > 0 && gnt_log.size() > 0) begin
            check(tag, gnt_log.pop_front(), exp_q.pop_front());
        end
        exp_q.delete();
        gnt_log.delete();
    endtask

    // Memory model: ack after ack_delay cycles of mem_req, one-cycle ack.
    initial begin
        busy_cnt = 0;
        forever begin
            @(negedge clk);
            if (model_en) begin
                if (mem_ack) begin
                    mem_ack  = 1'b0;
                    busy_cnt = 0;
                end else if (mem_req) begin
                    busy_cnt++;
                    if (busy_cnt >= ack_delay) begin
                        mem_ack = 1'b1;
                        if (mem_we) mem_arr[mem_addr[9:2]] = mem_wdata;
                        else        mem_rdata = mem_arr[mem_addr[9:2]];
                    end
                end
            end else begin
                busy_cnt = 0;
            end
        end
    end

    // Grant monitor: log mem_addr on each rising mem_req.
    initial begin
        logic prev;
        prev = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (mem_req && !prev) gnt_log.push_back(mem_addr);
            prev = mem_req;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: sim time exceeded, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    initial begin
        int  cyc;
        bit  got;
        bit  flag_a;
        bit  flag_b;
        int  d_cyc;
        int  i_cyc;
        int  d_done;
        bit  i_done;
        logic [31:0] seen_we;
        logic [31:0] seen_wd;
        logic [31:0] seen_ad;

        for (int k = 0; k < 256; k++) mem_arr[k] = 32'hA000_0000 + 32'(k);
        mem_arr[0] = 32'h8C22_0004;
        rst = 1'b1; i_req = 0; i_addr = 0; d_read = 0; d_write = 0;
        d_addr = 0; d_wdata = 0; mem_rdata = 0; mem_ack = 0;
        model_en = 1'b1; ack_delay = 1;

        // reset state
        apply_reset();
        check("rst_state", 32'(state_o), 32'd0);
        check("rst_mem_req", 32'(mem_req), 32'd0);
        check("rst_readys", 32'({i_ready, d_ready}), 32'd0);
        check("rst_mem_addr", mem_addr, 32'd0);
        check("rst_rdata", i_rdata | d_rdata, 32'd0);

        // 1: lone fetch, ack in third BUSY cycle
        ack_delay = 3;
        i_req = 1'b1; i_addr = 32'h0;
        cyc = 0; got = 0; flag_a = 1;
        while (cyc < 50) begin
            tick(); cyc++;
            if (i_ready) begin got = 1; break; end
            if (!stall_if) flag_a = 0;
        end
        check("t1_done", 32'(got), 32'd1);
        check("t1_latency", 32'(cyc), 32'd4);
        check("t1_rdata", i_rdata, 32'h8C22_0004);
        check("t1_stall_held", 32'(flag_a), 32'd1);
        check("t1_stall_drop", 32'(stall_if), 32'd0);
        i_req = 1'b0;
        tick();
        check("t1_pulse_1cyc", 32'(i_ready), 32'd0);
        check("t1_mem_req_low", 32'(mem_req), 32'd0);

        // 2: simultaneous fetch and load, data first
        apply_reset();
        ack_delay = 1;
        i_req = 1'b1; i_addr = 32'h200; d_read = 1'b1; d_addr = 32'h100;
        cyc = 0; d_cyc = 0; i_cyc = 0;
        while (cyc < 50) begin
            tick(); cyc++;
            if (d_ready) begin
                d_cyc = cyc;
                check("t2_d_rdata", d_rdata, 32'hA000_0040);
                check("t2_stalls", 32'({stall_mem, stall_if}), 32'b01);
                d_read = 1'b0;
            end
            if (i_ready) begin
                i_cyc = cyc;
                check("t2_i_rdata", i_rdata, 32'hA000_0080);
                i_req = 1'b0;
                break;
            end
        end
        check("t2_d_cyc", 32'(d_cyc), 32'd2);
        check("t2_i_cyc", 32'(i_cyc), 32'd5);
        tick();
        exp_q.push_back(32'h100);
        exp_q.push_back(32'h200);
        check_grants("t2_grant");

        // 3: starvation bound
        apply_reset();
        ack_delay = 1;
        i_req = 1'b1; i_addr = 32'h8; d_read = 1'b1; d_addr = 32'h300;
        cyc = 0; d_done = 0; i_done = 0;
        while (cyc < 200 && !(d_done == 5 && i_done)) begin
            tick(); cyc++;
            if (d_ready) begin
                check("t3_d_rdata", d_rdata, 32'hA000_0000 + (d_addr >> 2));
                d_done++;
                if (d_done == 5) d_read = 1'b0;
                else             d_addr = d_addr + 32'd4;
            end
            if (i_ready) begin
                check("t3_i_rdata", i_rdata, 32'hA000_0002);
                i_req = 1'b0;
                i_done = 1'b1;
            end
        end
        check("t3_done", 32'({i_done, d_done == 5}), 32'b11);
        tick();
        exp_q.push_back(32'h300);
        exp_q.push_back(32'h304);
        exp_q.push_back(32'h308);
        exp_q.push_back(32'h30C);
        exp_q.push_back(32'h008);
        exp_q.push_back(32'h310);
        check_grants("t3_grant");

        // 4: store keeps d_rdata from the last load (0x310)
        ack_delay = 2;
        @(negedge clk);
        d_write = 1'b1; d_addr = 32'h40; d_wdata = 32'hDEAD_BEEF;
        cyc = 0; got = 0; seen_we = 0; seen_wd = 0; seen_ad = 0;
        while (cyc < 50) begin
            tick(); cyc++;
            if (mem_req) begin
                seen_we = 32'(mem_we); seen_wd = mem_wdata; seen_ad = mem_addr;
            end
            if (d_ready) begin got = 1; break; end
        end
        check("t4_done", 32'(got), 32'd1);
        check("t4_latency", 32'(cyc), 32'd3);
        check("t4_mem_we", seen_we, 32'd1);
        check("t4_mem_wdata", seen_wd, 32'hDEAD_BEEF);
        check("t4_mem_addr", seen_ad, 32'h40);
        check("t4_d_rdata_held", d_rdata, 32'hA000_00C4);
        check("t4_mem_written", mem_arr[16], 32'hDEAD_BEEF);
        d_write = 1'b0;
        tick();
        check("t4_pulse_1cyc", 32'(d_ready), 32'd0);

        // 5: reset during D_BUSY, late ack ignored
        apply_reset();
        model_en = 1'b0; mem_ack = 1'b0; mem_rdata = 32'h5555_AAAA;
        d_read = 1'b1; d_addr = 32'h80;
        tick();
        check("t5_busy", 32'({state_o, mem_req}), 32'({2'd2, 1'b1}));
        @(negedge clk);
        rst = 1'b1; d_read = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        flag_a = 0; flag_b = 0;
        for (int k = 0; k < 6; k++) begin
            if (k == 1) mem_ack = 1'b1;
            if (k == 2) mem_ack = 1'b0;
            tick();
            if (d_ready || i_ready) flag_a = 1;
            if (mem_req || state_o != 2'd0) flag_b = 1;
            @(negedge clk);
        end
        check("t5_no_ready", 32'(flag_a), 32'd0);
        check("t5_idle_no_req", 32'(flag_b), 32'd0);
        check("t5_d_rdata", d_rdata, 32'd0);

        // 6: ack stuck high while idle, then a minimum-latency fetch
        mem_ack = 1'b1; mem_rdata = 32'h1234_5678;
        flag_a = 0; flag_b = 0;
        for (int k = 0; k < 10; k++) begin
            tick();
            if (d_ready || i_ready) flag_a = 1;
            if (mem_req || state_o != 2'd0) flag_b = 1;
        end
        check("t6_no_ready", 32'(flag_a), 32'd0);
        check("t6_idle_no_req", 32'(flag_b), 32'd0);
        @(negedge clk);
        i_req = 1'b1; i_addr = 32'h4;
        cyc = 0; got = 0;
        while (cyc < 50) begin
            tick(); cyc++;
            if (i_ready) begin got = 1; break; end
        end
        check("t6_done", 32'(got), 32'd1);
        check("t6_latency", 32'(cyc), 32'd2);
        check("t6_i_rdata", i_rdata, 32'h1234_5678);
        i_req = 1'b0;
        mem_ack = 1'b0;
        tick();
        check("t6_back_idle", 32'(state_o), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
